spi_instr_decoder: RTL

- Sequences the SPI slave bridge byte stream into register-bank transactions for the PWM generator.
- First byte of each frame is a command byte; subsequent bytes are data (write) or dummy (read).
- Drives single-cycle read/write strobes toward the register bank, and loads the bridge's transmit byte with read data before the next byte is shifted out.
- Sits between the bridge (byte_sync, data_in, data_out) and the register file.

---
 rtl/pwm_spi_pkg.sv | 20 ++
 rtl/sync_ff.sv | 25 ++
 rtl/spi_instr_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pwm_spi_pkg.sv
// Shared types and constants for the SPI command decoder of the PWM block.
package pwm_spi_pkg;

    localparam int unsigned ADDR_W        = 6;
    localparam int unsigned DATA_W        = 8;

    localparam int unsigned CMD_RW_BIT    = 7;
    localparam int unsigned CMD_BURST_BIT = 6;
    localparam int unsigned CMD_ADDR_MSB  = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_RD   = 3'd1,
        RD_FETCH = 3'd2,
        RD_WAIT  = 3'd3,
        WR_WAIT  = 3'd4,
        WR_PULSE = 3'd5
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_instr_decoder.sv
// Turns the SPI bridge byte stream into single-cycle register-bank
// read/write strobes and loads read data into the bridge transmit byte.
module spi_instr_decoder
    import pwm_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          BURST_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_write
);

    state_t            state;
    state_t            state_next;

    logic              cs_sync;
    logic              cs_prev;
    logic              cs_end;

    logic              burst;
    logic              burst_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W-1:0] data_write_d;
    logic              read_d;
    logic              write_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_sync)
    );

    // Delay the synchronised chip select by one cycle for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_prev <= 1'b1;
        end else begin
            cs_prev <= cs_sync;
        end
    end

    assign cs_end = cs_sync & ~cs_prev;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; end of frame overrides every transition
    always_comb begin
        state_next = state;
        if (cs_end) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (byte_sync) begin
                        state_next = data_in[CMD_RW_BIT] ? WR_WAIT : CMD_RD;
                    end
                end
                CMD_RD:   state_next = RD_FETCH;
                RD_FETCH: state_next = RD_WAIT;
                RD_WAIT: begin
                    if (byte_sync) begin
                        state_next = burst ? CMD_RD : IDLE;
                    end
                end
                WR_WAIT: begin
                    if (byte_sync) begin
                        state_next = WR_PULSE;
                    end
                end
                WR_PULSE: state_next = burst ? WR_WAIT : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Output/datapath next values. Strobes are registered from the next
    // state, so an abort (next state forced to IDLE) suppresses a pending
    // strobe while one already on the bus still completes its cycle.
    always_comb begin
        burst_d      = burst;
        addr_d       = addr;
        data_out_d   = data_out;
        data_write_d = data_write;
        read_d       = (state_next == CMD_RD);
        write_d      = (state_next == WR_PULSE);
        if (cs_end) begin
            burst_d    = 1'b0;
            data_out_d = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (byte_sync) begin
                        addr_d  = data_in[CMD_ADDR_MSB:0];
                        burst_d = data_in[CMD_BURST_BIT] & BURST_EN;
                    end
                end
                RD_FETCH: data_out_d = data_read;
                RD_WAIT: begin
                    if (byte_sync && burst) begin
                        addr_d = addr + ADDR_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (byte_sync) begin
                        data_write_d = data_in;
                    end
                end
                WR_PULSE: begin
                    if (burst) begin
                        addr_d = addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst      <= 1'b0;
            addr       <= '0;
            data_out   <= '0;
            data_write <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
        end else begin
            burst      <= burst_d;
            addr       <= addr_d;
            data_out   <= data_out_d;
            data_write <= data_write_d;
            read       <= read_d;
            write      <= write_d;
        end
    end

endmodule
